// File: rtl/or1k_rf_bypass_cappuccino_pkg.sv
// Shared register-file constants for the decode/execute operand path.
package or1k_rf_bypass_cappuccino_pkg;

    localparam int OR1K_OPERAND_WIDTH = 32;
    localparam int OR1K_RF_ADDR_WIDTH = 5;
    localparam int OR1K_RF_NUM_REGS   = 32;
    localparam int OR1K_RF_R0         = 0;

endpackage

// File: rtl/or1k_rf_bypass_port.sv
// One operand read port: captured address, bypassed/coherent operand
// register and the RAW hazard compare against the execute stage.
module or1k_rf_bypass_port
    import or1k_rf_bypass_cappuccino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = OR1K_OPERAND_WIDTH,
    parameter int OPTION_RF_ADDR_WIDTH = OR1K_RF_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rd_data_i,
    input  logic                            wr_en_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wr_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wr_data_i,
    input  logic                            exec_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] operand_o,
    output logic                            hazard_o
);

    localparam logic [OPTION_RF_ADDR_WIDTH-1:0] R0 = OPTION_RF_ADDR_WIDTH'(OR1K_RF_R0);

    logic [OPTION_RF_ADDR_WIDTH-1:0] r_adr;
    logic [OPTION_OPERAND_WIDTH-1:0] r_operand;
    logic                            w_capture_hit;
    logic                            w_hold_hit;

    // wr_en_i already excludes r0 and out-of-range targets, so neither can hit here
    assign w_capture_hit = wr_en_i && (wr_adr_i == adr_i);
    assign w_hold_hit    = wr_en_i && (wr_adr_i == r_adr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr     <= '0;
            r_operand <= '0;
        end else if (padv_decode_i) begin
            r_adr     <= adr_i;
            r_operand <= w_capture_hit ? wr_data_i : rd_data_i;
        end else if (w_hold_hit) begin
            r_operand <= wr_data_i;
        end
    end

    assign operand_o = r_operand;
    assign hazard_o  = exec_rf_wb_i && (exec_rfd_adr_i == r_adr) && (r_adr != R0);

endmodule

// File: rtl/or1k_rf_bypass_cappuccino.sv
// GPR array with two bypassing operand ports and the combined decode stall.
module or1k_rf_bypass_cappuccino
    import or1k_rf_bypass_cappuccino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = OR1K_OPERAND_WIDTH,
    parameter int OPTION_RF_ADDR_WIDTH = OR1K_RF_ADDR_WIDTH,
    parameter int OPTION_RF_NUM_REGS   = OR1K_RF_NUM_REGS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
    input  logic                            rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    input  logic                            exec_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
    output logic                            rfa_hazard_o,
    output logic                            rfb_hazard_o,
    output logic                            stall_o
);

    localparam logic [OPTION_RF_ADDR_WIDTH:0]   NUM_REGS_L = (OPTION_RF_ADDR_WIDTH+1)'(OPTION_RF_NUM_REGS);
    localparam logic [OPTION_RF_ADDR_WIDTH-1:0] R0         = OPTION_RF_ADDR_WIDTH'(OR1K_RF_R0);

    logic [OPTION_OPERAND_WIDTH-1:0] r_regs [0:OPTION_RF_NUM_REGS-1];

    logic                            w_wr_en;
    logic                            w_rfa_in_range;
    logic                            w_rfb_in_range;
    logic                            w_wb_in_range;
    logic [OPTION_OPERAND_WIDTH-1:0] w_rfa_rd;
    logic [OPTION_OPERAND_WIDTH-1:0] w_rfb_rd;

    assign w_rfa_in_range = {1'b0, rfa_adr_i}    < NUM_REGS_L;
    assign w_rfb_in_range = {1'b0, rfb_adr_i}    < NUM_REGS_L;
    assign w_wb_in_range  = {1'b0, wb_rfd_adr_i} < NUM_REGS_L;

    // r0 and out-of-range targets are filtered once here; the ports trust this enable
    assign w_wr_en = rf_wb_i && (wb_rfd_adr_i != R0) && w_wb_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OPTION_RF_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wb_rfd_adr_i] <= result_i;
        end
    end

    assign w_rfa_rd = w_rfa_in_range ? r_regs[rfa_adr_i] : '0;
    assign w_rfb_rd = w_rfb_in_range ? r_regs[rfb_adr_i] : '0;

    or1k_rf_bypass_port #(
        .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH),
        .OPTION_RF_ADDR_WIDTH (OPTION_RF_ADDR_WIDTH)
    ) u_port_a (
        .clk            (clk),
        .rst            (rst),
        .padv_decode_i  (padv_decode_i),
        .adr_i          (rfa_adr_i),
        .rd_data_i      (w_rfa_rd),
        .wr_en_i        (w_wr_en),
        .wr_adr_i       (wb_rfd_adr_i),
        .wr_data_i      (result_i),
        .exec_rf_wb_i   (exec_rf_wb_i),
        .exec_rfd_adr_i (exec_rfd_adr_i),
        .operand_o      (rfa_o),
        .hazard_o       (rfa_hazard_o)
    );

    or1k_rf_bypass_port #(
        .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH),
        .OPTION_RF_ADDR_WIDTH (OPTION_RF_ADDR_WIDTH)
    ) u_port_b (
        .clk            (clk),
        .rst            (rst),
        .padv_decode_i  (padv_decode_i),
        .adr_i          (rfb_adr_i),
        .rd_data_i      (w_rfb_rd),
        .wr_en_i        (w_wr_en),
        .wr_adr_i       (wb_rfd_adr_i),
        .wr_data_i      (result_i),
        .exec_rf_wb_i   (exec_rf_wb_i),
        .exec_rfd_adr_i (exec_rfd_adr_i),
        .operand_o      (rfb_o),
        .hazard_o       (rfb_hazard_o)
    );

    assign stall_o = rfa_hazard_o | rfb_hazard_o;

endmodule

// File: tb/tb_or1k_rf_bypass_cappuccino.sv
// Bench for the bypassing register-file read side: reference model plus directed literals.
module tb_or1k_rf_bypass_cappuccino;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_decode_i;
    logic [4:0]  rfa_adr_i;
    logic [4:0]  rfb_adr_i;
    logic        rf_wb_i;
    logic [4:0]  wb_rfd_adr_i;
    logic [31:0] result_i;
    logic        exec_rf_wb_i;
    logic [4:0]  exec_rfd_adr_i;
    logic [31:0] rfa_o;
    logic [31:0] rfb_o;
    logic        rfa_hazard_o;
    logic        rfb_hazard_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    or1k_rf_bypass_cappuccino dut (
        .clk            (clk),
        .rst            (rst),
        .padv_decode_i  (padv_decode_i),
        .rfa_adr_i      (rfa_adr_i),
        .rfb_adr_i      (rfb_adr_i),
        .rf_wb_i        (rf_wb_i),
        .wb_rfd_adr_i   (wb_rfd_adr_i),
        .result_i       (result_i),
        .exec_rf_wb_i   (exec_rf_wb_i),
        .exec_rfd_adr_i (exec_rfd_adr_i),
        .rfa_o          (rfa_o),
        .rfb_o          (rfb_o),
        .rfa_hazard_o   (rfa_hazard_o),
        .rfb_hazard_o   (rfb_hazard_o),
        .stall_o        (stall_o)
    );

    always #5 clk = ~clk;

    // Architectural model: register contents and what each operand port holds
    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    int          m_adr_a, m_adr_b;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_a = 32'd0; m_b = 32'd0;
            m_adr_a = 0; m_adr_b = 0;
        end else begin
            int wa;
            bit wr;
            wa = int'(wb_rfd_adr_i);
            wr = rf_wb_i && (wa != 0);
            if (padv_decode_i) begin
                m_a = (wr && wa == int'(rfa_adr_i)) ? result_i : m_regs[rfa_adr_i];
                m_b = (wr && wa == int'(rfb_adr_i)) ? result_i : m_regs[rfb_adr_i];
                m_adr_a = int'(rfa_adr_i);
                m_adr_b = int'(rfb_adr_i);
            end else begin
                if (wr && wa == m_adr_a) m_a = result_i;
                if (wr && wa == m_adr_b) m_b = result_i;
            end
            if (wr) m_regs[wa] = result_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            bit ha, hb;
            ha = exec_rf_wb_i && (int'(exec_rfd_adr_i) == m_adr_a) && (m_adr_a != 0);
            hb = exec_rf_wb_i && (int'(exec_rfd_adr_i) == m_adr_b) && (m_adr_b != 0);
            chk("model_rfa", rfa_o, m_a);
            chk("model_rfb", rfb_o, m_b);
            chk("model_haz_a", {31'd0, rfa_hazard_o}, {31'd0, ha});
            chk("model_haz_b", {31'd0, rfb_hazard_o}, {31'd0, hb});
            chk("model_stall", {31'd0, stall_o}, {31'd0, ha | hb});
        end
    end

    task automatic idle();
        padv_decode_i  = 1'b0;
        rf_wb_i        = 1'b0;
        exec_rf_wb_i   = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; padv_decode_i = 1'b0; rfa_adr_i = '0; rfb_adr_i = '0;
        rf_wb_i = 1'b0; wb_rfd_adr_i = '0; result_i = '0;
        exec_rf_wb_i = 1'b0; exec_rfd_adr_i = '0;
        tick();
        check_en = 1'b1;
        tick();
        chk("reset_rfa", rfa_o, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        idle();

        // capture r3/r4 after reset
        padv_decode_i = 1'b1; rfa_adr_i = 5'd3; rfb_adr_i = 5'd4;
        tick(); idle();
        chk("cap_r3", rfa_o, 32'd0);
        chk("cap_r4", rfb_o, 32'd0);
        chk("cap_stall", {31'd0, stall_o}, 32'd0);

        // plain write, then read back
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd5; result_i = 32'hDEADBEEF;
        tick(); idle();
        padv_decode_i = 1'b1; rfa_adr_i = 5'd5; rfb_adr_i = 5'd3;
        tick(); idle();
        chk("read_r5", rfa_o, 32'hDEADBEEF);

        // same-cycle bypass to both ports
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd7; result_i = 32'h0BAD0BAD;
        tick(); idle();
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd7; result_i = 32'h12345678;
        padv_decode_i = 1'b1; rfa_adr_i = 5'd7; rfb_adr_i = 5'd7;
        tick(); idle();
        chk("byp_a_r7", rfa_o, 32'h12345678);
        chk("byp_b_r7", rfb_o, 32'h12345678);

        // RAW hazard on A, resolved by later writeback through hold path
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd9; result_i = 32'h11;
        tick(); idle();
        padv_decode_i = 1'b1; rfa_adr_i = 5'd9; rfb_adr_i = 5'd4;
        tick(); idle();
        chk("old_r9", rfa_o, 32'h11);
        exec_rf_wb_i = 1'b1; exec_rfd_adr_i = 5'd9;
        #1;
        chk("haz_a_r9", {31'd0, rfa_hazard_o}, 32'd1);
        chk("haz_stall", {31'd0, stall_o}, 32'd1);
        tick(); idle();
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd9; result_i = 32'h22;
        tick(); idle();
        chk("hold_r9", rfa_o, 32'h22);
        chk("hold_stall", {31'd0, stall_o}, 32'd0);

        // r0 is constant zero, never bypasses and never hazards
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd0; result_i = 32'hFFFFFFFF;
        padv_decode_i = 1'b1; rfa_adr_i = 5'd0; rfb_adr_i = 5'd0;
        tick(); idle();
        exec_rf_wb_i = 1'b1; exec_rfd_adr_i = 5'd0;
        #1;
        chk("r0_val", rfa_o, 32'd0);
        chk("r0_haz", {31'd0, rfa_hazard_o}, 32'd0);
        tick(); idle();
        padv_decode_i = 1'b1; rfa_adr_i = 5'd0;
        tick(); idle();
        chk("r0_reread", rfa_o, 32'd0);

        // sweep: fill every register, then cross-read with bypass on the last one
        for (int i = 1; i < 32; i++) begin
            rf_wb_i = 1'b1; wb_rfd_adr_i = 5'(i); result_i = 32'h01010101 * i;
            padv_decode_i = 1'b1; rfa_adr_i = 5'(i); rfb_adr_i = 5'(32 - i);
            tick(); idle();
        end
        chk("sweep_a31", rfa_o, 32'h1F1F1F1F);
        chk("sweep_b1", rfb_o, 32'h01010101);

        // hazard on B, then reset mid-hazard
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd6; result_i = 32'h55;
        tick(); idle();
        padv_decode_i = 1'b1; rfa_adr_i = 5'd2; rfb_adr_i = 5'd6;
        tick(); idle();
        exec_rf_wb_i = 1'b1; exec_rfd_adr_i = 5'd6;
        #1;
        chk("haz_b_r6", {31'd0, rfb_hazard_o}, 32'd1);
        chk("val_b_r6", rfb_o, 32'h55);
        rst = 1'b1;
        rf_wb_i = 1'b1; wb_rfd_adr_i = 5'd6; result_i = 32'h99;
        padv_decode_i = 1'b1; rfb_adr_i = 5'd6;
        tick();
        rst = 1'b0; rf_wb_i = 1'b0; padv_decode_i = 1'b0;
        #1;
        chk("rst_b_val", rfb_o, 32'd0);
        chk("rst_b_haz", {31'd0, rfb_hazard_o}, 32'd0);
        idle();
        padv_decode_i = 1'b1; rfa_adr_i = 5'd5; rfb_adr_i = 5'd6;
        tick(); idle();
        chk("rst_reread_r6", rfb_o, 32'd0);
        chk("rst_reread_r5", rfa_o, 32'd0);

        tick();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
